plab2_proc_imul_arb: RTL

PLAB2_PROC_IMUL_ARB -- requirements
Module: plab2_proc_imul_arb

---
 rtl/plab2_proc_imul_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/plab2_proc_imul_arb.sv
// Two-requester arbiter in front of one shared variable-latency multiplier.
// Requests are granted round-robin, and a two-entry owner FIFO records who
// issued each outstanding multiply. Responses are steered back in issue order.
// Payloads pass straight through; only prio, the owner FIFO and err are registered.
//
// Handshake: a transfer happens on a rising clk edge when val && rdy are both
// high. val never waits on rdy. Grant and request valid never depend on
// mul_req_rdy.
module plab2_proc_imul_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic [66:0] req0_msg,
  input  logic        req1_val,
  output logic        req1_rdy,
  input  logic [66:0] req1_msg,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [31:0] resp0_msg,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic [31:0] resp1_msg,
  output logic        mul_req_val,
  input  logic        mul_req_rdy,
  output logic [66:0] mul_req_msg,
  input  logic        mul_resp_val,
  output logic        mul_resp_rdy,
  input  logic [31:0] mul_resp_msg,
  output logic [1:0]  inflight,
  output logic        err
);

  logic       prio_q, prio_d;
  logic [1:0] ent_q, ent_d;   // owner ids, bit 0 is the head
  logic [1:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  logic gnt_val, gnt_id;
  logic full, empty, head;
  logic push, pop;

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = ent_q[0];

  // Grant from the valids and the priority pointer only.
  always_comb begin
    gnt_val = req0_val | req1_val;
    gnt_id  = 1'b0;
    if (prio_q) gnt_id = req1_val ? 1'b1 : 1'b0;
    else        gnt_id = req0_val ? 1'b0 : 1'b1;
  end

  // Request side: pass the granted message through, gate rdy on FIFO space.
  always_comb begin
    mul_req_val = gnt_val && !full;
    mul_req_msg = (gnt_val && gnt_id) ? req1_msg : req0_msg;
    req0_rdy    = gnt_val && !gnt_id && mul_req_rdy && !full;
    req1_rdy    = gnt_val &&  gnt_id && mul_req_rdy && !full;
  end

  // Response side: only the FIFO head owner may see a response.
  always_comb begin
    resp0_val    = mul_resp_val && !empty && !head;
    resp1_val    = mul_resp_val && !empty &&  head;
    mul_resp_rdy = !empty && (head ? resp1_rdy : resp0_rdy);
    resp0_msg    = mul_resp_msg;
    resp1_msg    = mul_resp_msg;
  end

  assign push = mul_req_val && mul_req_rdy;
  assign pop  = mul_resp_val && mul_resp_rdy;

  // Next state of prio, owner FIFO and the sticky error flag.
  always_comb begin
    prio_d = prio_q;
    ent_d  = ent_q;
    cnt_d  = cnt_q;
    err_d  = err_q | (mul_resp_val && empty);
    if (push) prio_d = ~gnt_id;
    // Push while full cannot happen, and pop while empty cannot happen, so
    // push+pop together only happens at count 1.
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent_d[0] = gnt_id;
        else               ent_d[1] = gnt_id;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent_d[0] = ent_q[1];
        cnt_d    = cnt_q - 2'd1;
      end
      2'b11: begin
        ent_d[0] = gnt_id;
      end
      default: ;
    endcase
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= 1'b0;
      ent_q  <= 2'b00;
      cnt_q  <= 2'd0;
      err_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      ent_q  <= ent_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign inflight = cnt_q;
  assign err      = err_q;

endmodule
